train_pass_scheduler: RTL and testbench

Sequences one training step through the neural-net register/delay pipeline. It issues one (layer, row) work item per handshake: a forward sweep over all layers, then an optional backward/update sweep in reverse layer order. It drives the w_layer_index, w_row_index, is_update, backprop_cost, cost_type and dense_type inputs of the first pipeline stage. It tracks in-flight items through the retire pulses returned at the pipeline tail.

---
 rtl/train_pass_scheduler_if.sv | 28 ++
 rtl/train_pass_scheduler.sv | 256 +++++++++++++++++++++++++
 tb/tb_train_pass_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/train_pass_scheduler_if.sv
// Issue/retire channel between the training-pass scheduler and the first
// stage of the register/delay pipeline. The scheduler uses the master modport.
interface train_pass_scheduler_if #(
    parameter int cost_type_size  = 8,
    parameter int dense_type_size = 4
);
    logic                       issue_valid;
    logic                       issue_ready;
    logic [31:0]                w_layer_index;
    logic [31:0]                w_row_index;
    logic                       is_update;
    logic                       backprop_cost;
    logic [cost_type_size-1:0]  cost_type_out;
    logic [dense_type_size-1:0] dense_type_out;
    logic                       retire;

    modport master (
        output issue_valid, w_layer_index, w_row_index, is_update,
               backprop_cost, cost_type_out, dense_type_out,
        input  issue_ready, retire
    );

    modport slave (
        input  issue_valid, w_layer_index, w_row_index, is_update,
               backprop_cost, cost_type_out, dense_type_out,
        output issue_ready, retire
    );
endinterface

// File: rtl/train_pass_scheduler.sv
// Issues (layer,row) items for one training step: forward sweep, then optional
// backward sweep. Optional counters are enabled with TRAIN_PASS_STATS_EN.
module train_pass_scheduler #(
    parameter int NUM_LAYERS      = 3,
    parameter int ROWS            = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int cost_type_size  = 8,
    parameter int dense_type_size = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       train,
    input  logic                       abort,
    input  logic [cost_type_size-1:0]  cost_type,
    input  logic [dense_type_size-1:0] dense_type,
    train_pass_scheduler_if.master     pipe,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 outstanding,
    output logic                       err
`ifdef TRAIN_PASS_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                pass_cycles
`endif
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
    localparam logic [7:0]    MAX_OUT    = 8'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FWD     = 3'd1,
        S_DRAIN_F = 3'd2,
        S_BWD     = 3'd3,
        S_DRAIN_B = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [LW-1:0]              layer_q, layer_d;
    logic [RW-1:0]              row_q, row_d;
    logic                       train_q, train_d;
    logic                       aborted_q, aborted_d;
    logic [cost_type_size-1:0]  cost_q, cost_d;
    logic [dense_type_size-1:0] dense_q, dense_d;
    logic [7:0]                 out_q, out_d;
    logic                       err_q, err_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       is_update_q, is_update_d;
    logic                       backprop_q, backprop_d;

    logic                       issuing_s;
    logic                       valid_s;
    logic                       fire_s;
    logic                       retire_ok_s;

    // Issue handshake: abort kills issue_valid combinationally so no item fires that cycle
    always_comb begin
        issuing_s   = (state_q == S_FWD) || (state_q == S_BWD);
        valid_s     = issuing_s && (out_q < MAX_OUT) && !abort;
        fire_s      = valid_s && pipe.issue_ready;
        retire_ok_s = pipe.retire && (out_q != 8'd0);
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            layer_q     <= '0;
            row_q       <= '0;
            train_q     <= 1'b0;
            aborted_q   <= 1'b0;
            cost_q      <= '0;
            dense_q     <= '0;
            out_q       <= 8'd0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            is_update_q <= 1'b0;
            backprop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            row_q       <= row_d;
            train_q     <= train_d;
            aborted_q   <= aborted_d;
            cost_q      <= cost_d;
            dense_q     <= dense_d;
            out_q       <= out_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            is_update_q <= is_update_d;
            backprop_q  <= backprop_d;
        end
    end

    // Next-state logic and sweep index sequencing; indices hold on the final fire of a sweep
    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        train_d   = train_q;
        aborted_d = aborted_q;
        cost_d    = cost_q;
        dense_d   = dense_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    train_d   = train;
                    cost_d    = cost_type;
                    dense_d   = dense_type;
                    layer_d   = '0;
                    row_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = S_FWD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FWD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN_B;
                end else if (fire_s) begin
                    if (row_q == LAST_ROW) begin
                        if (layer_q == LAST_LAYER) begin
                            state_d = S_DRAIN_F;
                        end else begin
                            layer_d = layer_q + LW'(1);
                            row_d   = '0;
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    state_d = S_FWD;
                end
            end
            S_DRAIN_F: begin
                if ((out_q == 8'd0) && !pipe.retire) begin
                    if (train_q) begin
                        state_d = S_BWD;
                        layer_d = LAST_LAYER;
                        row_d   = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_DRAIN_F;
                end
            end
            S_BWD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DRAIN_B;
                end else if (fire_s) begin
                    if (row_q == LAST_ROW) begin
                        if (layer_q == '0) begin
                            state_d = S_DRAIN_B;
                        end else begin
                            layer_d = layer_q - LW'(1);
                            row_d   = '0;
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    state_d = S_BWD;
                end
            end
            S_DRAIN_B: begin
                if (out_q == 8'd0) begin
                    state_d = aborted_q ? S_IDLE : S_DONE;
                end else begin
                    state_d = S_DRAIN_B;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; a retire with nothing in flight is dropped and flagged
    always_comb begin
        out_d       = out_q + {7'd0, fire_s} - {7'd0, retire_ok_s};
        err_d       = err_q | (pipe.retire && (out_q == 8'd0));
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        is_update_d = (state_d == S_BWD);
        backprop_d  = (state_d == S_BWD) && (layer_d == LAST_LAYER);
    end

    assign pipe.issue_valid    = valid_s;
    assign pipe.w_layer_index  = 32'(layer_q);
    assign pipe.w_row_index    = 32'(row_q);
    assign pipe.is_update      = is_update_q;
    assign pipe.backprop_cost  = backprop_q;
    assign pipe.cost_type_out  = cost_q;
    assign pipe.dense_type_out = dense_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign outstanding         = out_q;
    assign err                 = err_q;

`ifdef TRAIN_PASS_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] pass_q, pass_d;

    // Saturating stall/busy counters, cleared when a pass is accepted
    always_comb begin
        stall_d = stall_q;
        pass_d  = pass_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = 32'd0;
            pass_d  = 32'd0;
        end else begin
            if (valid_s && !pipe.issue_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_d = stall_q + 32'd1;
            end else begin
                stall_d = stall_q;
            end
            if (busy_q && (pass_q != 32'hFFFF_FFFF)) begin
                pass_d = pass_q + 32'd1;
            end else begin
                pass_d = pass_q;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            pass_q  <= 32'd0;
        end else begin
            stall_q <= stall_d;
            pass_q  <= pass_d;
        end
    end

    assign stall_cycles = stall_q;
    assign pass_cycles  = pass_q;
`endif

endmodule

// File: tb/tb_train_pass_scheduler.sv
// Bench for train_pass_scheduler: a cycle table for backpressure, then
// randomized passes checked against an item-list reference model.
module tb_train_pass_scheduler;
    localparam int NL   = 3;
    localparam int NR   = 2;
    localparam int MO   = 4;
    localparam int CW   = 8;
    localparam int DW   = 4;
    localparam int FWDN = NL * NR;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          train;
    logic          abort;
    logic [CW-1:0] cost_type;
    logic [DW-1:0] dense_type;
    logic          busy;
    logic          done;
    logic [7:0]    outstanding;
    logic          err;
`ifdef TRAIN_PASS_STATS_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   pass_cycles;
`endif

    train_pass_scheduler_if #(.cost_type_size(CW), .dense_type_size(DW)) pipe_if ();

    train_pass_scheduler #(
        .NUM_LAYERS(NL), .ROWS(NR), .MAX_OUTSTANDING(MO),
        .cost_type_size(CW), .dense_type_size(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .train(train), .abort(abort),
        .cost_type(cost_type), .dense_type(dense_type), .pipe(pipe_if),
        .busy(busy), .done(done), .outstanding(outstanding), .err(err)
`ifdef TRAIN_PASS_STATS_EN
        , .stall_cycles(stall_cycles), .pass_cycles(pass_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit start, abort, ready, retire;
        bit exp_valid;
        int exp_layer, exp_row, exp_out;
        bit exp_busy, exp_done;
    } vec_t;

    typedef struct {
        int layer;
        int row;
        bit upd;
        bit bp;
    } item_t;

    int n_pass  = 0;
    int n_total = 0;
    int m_out   = 0;
    bit err_m   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(bit s, bit a, bit rd, bit rt, bit v, int l, int r, int o, bit b, bit d);
        vec_t x;
        x.start = s; x.abort = a; x.ready = rd; x.retire = rt;
        x.exp_valid = v; x.exp_layer = l; x.exp_row = r; x.exp_out = o;
        x.exp_busy = b; x.exp_done = d;
        return x;
    endfunction

    // One pass with random backpressure; expectations come from the item list built from the sweep rules
    task automatic run_pass(input bit tr, input int ready_pct, input int dly, input int abort_k);
        item_t         exp_q[$];
        int            due_q[$];
        item_t         e;
        int            fires, dones, prev_l, prev_r;
        bit            aborted, finished, prev_stall, fire_s;
        logic [CW-1:0] cv;
        logic [DW-1:0] dv;
        for (int l = 0; l < NL; l++)
            for (int r = 0; r < NR; r++)
                exp_q.push_back('{layer: l, row: r, upd: 1'b0, bp: 1'b0});
        if (tr)
            for (int l = NL - 1; l >= 0; l--)
                for (int r = 0; r < NR; r++)
                    exp_q.push_back('{layer: l, row: r, upd: 1'b1, bp: (l == NL - 1)});
        cv = CW'($urandom);
        dv = DW'($urandom);
        start = 1'b1; train = tr; cost_type = cv; dense_type = dv; abort = 1'b0;
        pipe_if.retire = 1'b0; pipe_if.issue_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0; train = ~tr; cost_type = ~cv; dense_type = ~dv;
        fires = 0; dones = 0; aborted = 1'b0; finished = 1'b0; prev_stall = 1'b0;
        prev_l = 0; prev_r = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            pipe_if.retire = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                pipe_if.retire = 1'b1;
                void'(due_q.pop_front());
            end
            pipe_if.issue_ready = ($urandom_range(99) < ready_pct);
            abort = (!aborted && abort_k >= 0 && fires == abort_k);
            @(negedge clk);
            if (abort) begin
                chk("abort_valid", pipe_if.issue_valid, 0);
                aborted = 1'b1;
            end else if (cyc == 0) begin
                chk("start_latency", pipe_if.issue_valid, 1);
            end
            chk("outstanding", outstanding, m_out);
            chk("err", err, err_m);
            if (pipe_if.issue_valid) chk("valid_room", (m_out < MO), 1);
            if (prev_stall && pipe_if.issue_valid) begin
                chk("hold_layer", pipe_if.w_layer_index, prev_l);
                chk("hold_row", pipe_if.w_row_index, prev_r);
            end
            fire_s = pipe_if.issue_valid && pipe_if.issue_ready;
            if (fire_s) begin
                fires++;
                if (aborted) chk("fire_after_abort", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("extra_item", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("item_layer", pipe_if.w_layer_index, e.layer);
                    chk("item_row", pipe_if.w_row_index, e.row);
                    chk("item_update", pipe_if.is_update, e.upd);
                    chk("item_backprop", pipe_if.backprop_cost, e.bp);
                    chk("item_cost", pipe_if.cost_type_out, cv);
                    chk("item_dense", pipe_if.dense_type_out, dv);
                    if (e.upd && fires == FWDN + 1) chk("drain_before_bwd", m_out, 0);
                end
                due_q.push_back(cyc + dly);
            end
            prev_stall = pipe_if.issue_valid && !pipe_if.issue_ready;
            prev_l = int'(pipe_if.w_layer_index);
            prev_r = int'(pipe_if.w_row_index);
            if (done) begin
                dones++;
                chk("done_clean", exp_q.size() + m_out + int'(aborted), 0);
            end
            if (pipe_if.retire) begin
                if (m_out == 0) err_m = 1'b1;
                else m_out--;
            end
            if (fire_s) m_out++;
            if (cyc > 0 && !busy) begin
                finished = 1'b1;
                chk("done_count", dones, aborted ? 0 : 1);
                if (!aborted) chk("items_left", exp_q.size(), 0);
            end
            @(posedge clk); #1;
        end
        if (!finished) chk("pass_timeout", 0, 1);
        pipe_if.retire = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        vec_t tbl[18];
        bit   found;
        tbl[0]  = mk(1,0,1,0, 0,0,0,0,0,0);
        tbl[1]  = mk(0,0,1,0, 1,0,0,0,1,0);
        tbl[2]  = mk(0,0,1,0, 1,0,1,1,1,0);
        tbl[3]  = mk(0,0,1,0, 1,1,0,2,1,0);
        tbl[4]  = mk(0,0,1,0, 1,1,1,3,1,0);
        tbl[5]  = mk(0,0,1,0, 0,2,0,4,1,0);
        tbl[6]  = mk(0,0,1,0, 0,2,0,4,1,0);
        tbl[7]  = mk(0,0,1,1, 0,2,0,4,1,0);
        tbl[8]  = mk(0,0,1,0, 1,2,0,3,1,0);
        tbl[9]  = mk(0,0,1,0, 0,2,1,4,1,0);
        tbl[10] = mk(0,0,1,1, 0,2,1,4,1,0);
        tbl[11] = mk(0,0,1,1, 1,2,1,3,1,0);
        tbl[12] = mk(0,0,1,1, 0,2,1,3,1,0);
        tbl[13] = mk(0,0,1,1, 0,2,1,2,1,0);
        tbl[14] = mk(0,0,1,1, 0,2,1,1,1,0);
        tbl[15] = mk(0,0,1,0, 0,2,1,0,1,0);
        tbl[16] = mk(0,0,1,0, 0,2,1,0,1,1);
        tbl[17] = mk(0,0,1,0, 0,2,1,0,0,0);

        rst_n = 1'b0; start = 1'b0; train = 1'b0; abort = 1'b0;
        cost_type = '0; dense_type = '0;
        pipe_if.issue_ready = 1'b0; pipe_if.retire = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", pipe_if.issue_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_layer", pipe_if.w_layer_index, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Backpressure from the outstanding limit, then drain and done
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start; abort = tbl[i].abort;
            pipe_if.issue_ready = tbl[i].ready; pipe_if.retire = tbl[i].retire;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), pipe_if.issue_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_layer", i), pipe_if.w_layer_index, tbl[i].exp_layer);
            chk($sformatf("tbl%0d_row", i), pipe_if.w_row_index, tbl[i].exp_row);
            chk($sformatf("tbl%0d_out", i), outstanding, tbl[i].exp_out);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
            @(posedge clk); #1;
        end
        start = 1'b0; pipe_if.retire = 1'b0;

        run_pass(1'b0, 100, 3, -1);
        run_pass(1'b1, 100, 3, -1);
        run_pass(1'b1, 40, 1, -1);
        for (int p = 0; p < 12; p++)
            run_pass(1'($urandom_range(1)), $urandom_range(30, 100), $urandom_range(1, 6),
                     ($urandom_range(3) == 0) ? $urandom_range(0, FWDN - 1) : -1);
        run_pass(1'b0, 100, 2, 3);

        // Spurious retire with nothing in flight
        pipe_if.retire = 1'b1;
        @(negedge clk);
        chk("spurious_out_before", outstanding, 0);
        @(posedge clk); #1;
        pipe_if.retire = 1'b0;
        @(negedge clk);
        chk("spurious_err", err, 1);
        chk("spurious_out_after", outstanding, 0);
        err_m = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of the backward sweep
        start = 1'b1; train = 1'b1; pipe_if.issue_ready = 1'b1; pipe_if.retire = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            pipe_if.retire = (outstanding != 8'd0);
            @(negedge clk);
            if (pipe_if.is_update) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reach_bwd", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", pipe_if.issue_valid, 0);
        chk("arst_layer", pipe_if.w_layer_index, 0);
        chk("arst_row", pipe_if.w_row_index, 0);
        chk("arst_update", pipe_if.is_update, 0);
        chk("arst_backprop", pipe_if.backprop_cost, 0);
        chk("arst_cost", pipe_if.cost_type_out, 0);
        chk("arst_dense", pipe_if.dense_type_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_out", outstanding, 0);
        chk("arst_err", err, 0);
        pipe_if.retire = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_out = 0;
        err_m = 1'b0;
        @(posedge clk); #1;
        run_pass(1'b0, 100, 3, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
